// File: rtl/control_unit.sv
// rtl/control_unit.sv - registered main instruction decoder for the 16-bit processor
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [3:0] function_code,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       Branch,
    output logic       Jump,
    output logic [3:0] ALUop,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWriteSource,
    output logic       ALUSource
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;

    logic       reg_dst_d;
    logic       reg_write_d;
    logic       branch_d;
    logic       jump_d;
    logic [3:0] alu_op_d;
    logic       mem_read_d;
    logic       mem_write_d;
    logic       wb_source_d;
    logic       alu_source_d;

    // Explicit case items (never pass-through) keep unknown fields from reaching the flops.
    always_comb begin
        reg_dst_d    = 1'b0;
        reg_write_d  = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        alu_op_d     = ALU_ADD;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        wb_source_d  = 1'b0;
        alu_source_d = 1'b0;
        case (opcode)
            4'b0000: begin
                case (function_code)
                    4'b0000: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = ALU_ADD; end
                    4'b0001: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = ALU_SUB; end
                    4'b0010: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = ALU_SLL; end
                    4'b0011: begin reg_dst_d = 1'b1; reg_write_d = 1'b1; alu_op_d = ALU_AND; end
                    default: ;
                endcase
            end
            4'b0001: begin
                reg_write_d  = 1'b1;
                mem_read_d   = 1'b1;
                wb_source_d  = 1'b1;
                alu_source_d = 1'b1;
            end
            4'b0010: begin
                mem_write_d  = 1'b1;
                alu_source_d = 1'b1;
            end
            4'b0011: begin
                reg_write_d  = 1'b1;
                alu_source_d = 1'b1;
            end
            4'b0100, 4'b0101: begin
                branch_d = 1'b1;
                alu_op_d = ALU_SUB;
            end
            4'b0110: jump_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegDst         <= 1'b0;
            RegWrite       <= 1'b0;
            Branch         <= 1'b0;
            Jump           <= 1'b0;
            ALUop          <= ALU_ADD;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            RegWriteSource <= 1'b0;
            ALUSource      <= 1'b0;
        end else begin
            RegDst         <= reg_dst_d;
            RegWrite       <= reg_write_d;
            Branch         <= branch_d;
            Jump           <= jump_d;
            ALUop          <= alu_op_d;
            MemRead        <= mem_read_d;
            MemWrite       <= mem_write_d;
            RegWriteSource <= wb_source_d;
            ALUSource      <= alu_source_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized and directed checks of control_unit against a rule-based model
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [3:0] function_code;
    logic       RegDst, RegWrite, Branch, Jump;
    logic [3:0] ALUop;
    logic       MemRead, MemWrite, RegWriteSource, ALUSource;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .function_code  (function_code),
        .RegDst         (RegDst),
        .RegWrite       (RegWrite),
        .Branch         (Branch),
        .Jump           (Jump),
        .ALUop          (ALUop),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .RegWriteSource (RegWriteSource),
        .ALUSource      (ALUSource)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {RegDst, RegWrite, Branch, Jump, ALUop[3:0], MemRead, MemWrite, RegWriteSource, ALUSource}
    function automatic logic [11:0] pack_out();
        return {RegDst, RegWrite, Branch, Jump, ALUop, MemRead, MemWrite, RegWriteSource, ALUSource};
    endfunction

    function automatic logic [11:0] model(input logic r, input logic [3:0] op, input logic [3:0] fn);
        logic rd, rw, br, jp, mr, mw, ws, as_;
        logic [3:0] alu;
        rd = 0; rw = 0; br = 0; jp = 0; mr = 0; mw = 0; ws = 0; as_ = 0; alu = 4'd0;
        if (r || $isunknown(op)) return 12'd0;
        if (op == 4'd0) begin
            if (!$isunknown(fn) && fn < 4'd4) begin
                rd = 1; rw = 1; alu = fn;
            end
        end else begin
            mr  = (op == 4'd1);
            mw  = (op == 4'd2);
            rw  = (op == 4'd1) || (op == 4'd3);
            ws  = mr;
            as_ = (op >= 4'd1) && (op <= 4'd3);
            br  = (op == 4'd4) || (op == 4'd5);
            jp  = (op == 4'd6);
            alu = br ? 4'd1 : 4'd0;
        end
        return {rd, rw, br, jp, alu, mr, mw, ws, as_};
    endfunction

    logic [11:0] expected;
    logic        valid = 1'b0;

    always @(posedge clk) begin
        expected <= model(rst, opcode, function_code);
        valid    <= valid | rst;
    end

    always @(negedge clk) begin
        if (valid) begin
            checks++;
            if (pack_out() !== expected) begin
                errors++;
                $display("FAIL model_compare t=%0t actual=%b required=%b", $time, pack_out(), expected);
            end
            checks++;
            if ((MemRead & MemWrite) || (Branch & Jump) || (RegWriteSource & ~MemRead)) begin
                errors++;
                $display("FAIL exclusivity t=%0t actual=%b required=no_conflict", $time, pack_out());
            end
        end
    end

    task automatic apply(input logic r, input logic [3:0] op, input logic [3:0] fn);
        rst = r;
        opcode = op;
        function_code = fn;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [11:0] req);
        checks++;
        if (pack_out() !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, pack_out(), req);
        end
    endtask

    localparam logic [11:0] V_LW   = 12'b0100_0000_1011;
    localparam logic [11:0] V_SW   = 12'b0000_0000_0101;
    localparam logic [11:0] V_ADDI = 12'b0100_0000_0001;
    localparam logic [11:0] V_BR   = 12'b0010_0001_0000;
    localparam logic [11:0] V_JMP  = 12'b0001_0000_0000;

    initial begin
        rst = 1'b1;
        opcode = 4'b0001;
        function_code = 4'b0000;
        apply(1'b1, 4'b0001, 4'b0000);
        apply(1'b1, 4'b0001, 4'b0000);
        lit("reset_clear", 12'd0);
        apply(1'b0, 4'b0001, 4'bxxxx);
        lit("lw_after_reset", V_LW);

        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 4'b0000, 4'(k));
            lit("rtype_sweep", {4'b1100, 4'(k), 4'b0000});
        end

        apply(1'b0, 4'b0010, 4'bxxxx);
        lit("sw_fx", V_SW);
        apply(1'b0, 4'b0011, 4'bxxxx);
        lit("addi_fx", V_ADDI);
        apply(1'b0, 4'b0100, 4'b0000);
        lit("beq", V_BR);
        apply(1'b0, 4'b0101, 4'b1010);
        lit("bne", V_BR);
        apply(1'b0, 4'b0110, 4'b0011);
        lit("jmp", V_JMP);
        apply(1'b0, 4'b0000, 4'b0111);
        lit("rtype_illegal_fn", 12'd0);
        apply(1'b0, 4'b1111, 4'b0000);
        lit("opcode_1111", 12'd0);

        apply(1'b0, 4'b0011, 4'b0000);
        opcode = 4'b0110;
        #2;
        lit("latency_hold", V_ADDI);
        @(posedge clk);
        #1;
        lit("latency_update", V_JMP);

        apply(1'b0, 4'b0011, 4'b0101);
        apply(1'b1, 4'b0011, 4'b0101);
        lit("mid_reset", 12'd0);
        apply(1'b0, 4'b0011, 4'b0101);
        lit("addi_resume", V_ADDI);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [3:0] fn;
            op = 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 15));
            if (op != 4'd0 && $urandom_range(0, 3) == 0) fn = 4'bxxxx;
            apply($urandom_range(0, 19) == 0, op, fn);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
